rx_controller: RTL and testbench
================================

RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port i_rx_data, input, 1, asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 The block SHALL have port o_rx_byte, output, 8, last correctly framed received byte.
REQ-006 The block SHALL have port o_rx_valid, output, 1, one-cycle pulse when o_rx_byte updates.
REQ-007 The block SHALL have port o_rx_active, output, 1, high while a frame is in progress (any state other than IDLE).
REQ-008 The block SHALL have port o_rx_frame_err, output, 1, one-cycle pulse when the stop bit samples low.

Function
REQ-009 i_rx_data SHALL pass through a 2-flop synchronizer, both flops reset to 1; all logic below uses only the synchronized value.
REQ-010 A bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, cleared on every state entry, and SHALL never wrap within a bit.
REQ-011 State machine states SHALL be IDLE, START, DATA, STOP; any unreachable encoding SHALL go to IDLE on the next cycle.
REQ-012 IDLE: a falling edge SHALL move to START with the counter cleared; a falling edge is previous synchronized sample 1 and current sample 0.
REQ-013 IDLE: a line held low without a falling edge (break or stuck-low) SHALL NOT start a frame.
REQ-014 START: at count == (CLKS_PER_BIT-1)/2 (integer division), a sample of 0 SHALL move to DATA with the counter and bit index cleared.
REQ-015 START: at the same count, a sample of 1 SHALL be treated as a glitch and SHALL return to IDLE with no output pulse.
REQ-016 DATA: at count == CLKS_PER_BIT-1, the sample SHALL be written into internal shift-register bit [bit_index] and the counter cleared.
REQ-017 DATA: bit_index SHALL increment from 0 to 7; after the bit-7 sample the state SHALL move to STOP.
REQ-018 STOP: at count == CLKS_PER_BIT-1, a sample of 1 SHALL load o_rx_byte from the shift register and pulse o_rx_valid for exactly one cycle.
REQ-019 STOP: at the same count, a sample of 0 SHALL pulse o_rx_frame_err for exactly one cycle and SHALL leave o_rx_byte unchanged.
REQ-020 STOP SHALL return to IDLE in the same cycle as the REQ-018/REQ-019 pulse.
REQ-021 o_rx_valid and o_rx_frame_err SHALL never be high together, and SHALL be low in every cycle other than the STOP-sample cycle.
REQ-022 o_rx_byte SHALL hold its value until the next valid frame; a new byte overwrites the old one with no overrun flag.
REQ-023 A frame whose start edge arrives in the first IDLE cycle after STOP SHALL be received without loss.
REQ-024 The o_rx_valid pulse SHALL occur 2 synchronizer cycles + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + a fixed pipeline of at most 2 cycles after the line falling edge; the implementation SHALL document the exact figure.

Reset
REQ-025 While reset is low, the block SHALL be in IDLE with counter 0 and bit index 0.
REQ-026 While reset is low, the synchronizer and edge flops SHALL hold 1, o_rx_byte 8'h00, o_rx_valid 0, o_rx_active 0, o_rx_frame_err 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no pulse; reception resumes on the first falling edge after reset release.

Verification
REQ-028 CLKS_PER_BIT=16, frame 0xA5 with stop=1 -> o_rx_byte=8'hA5, o_rx_valid high for exactly 1 cycle, o_rx_frame_err stays 0, o_rx_active low afterwards.
REQ-029 Low glitch of 4 cycles on an idle line -> START aborts at the half-bit sample, no pulses, o_rx_active high for at most 10 cycles.
REQ-030 Frame 0x3C with stop=0 -> o_rx_frame_err pulses 1 cycle, o_rx_byte keeps its prior value; the line then held low -> no new frame until a high-then-low edge.
REQ-031 Back-to-back frames 0x00 then 0xFF with zero idle gap -> two o_rx_valid pulses carrying 8'h00 then 8'hFF.
REQ-032 Reset pulsed during DATA bit 3 -> all outputs at reset values immediately; the next full frame 0x81 is received correctly.
REQ-033 CLKS_PER_BIT=4, frames 0x55 and 0xAA -> both received correctly (minimum-ratio sampling check).

Source files
------------

// File: rtl/rx_controller.sv
// rx_controller: 8N1 UART receiver, LSB first, idle-high line.
// The line passes a 2-flop synchronizer. A falling edge in IDLE starts a frame.
// The start bit is re-checked at its middle. Each data bit and the stop bit are
// then sampled CLKS_PER_BIT cycles apart.
//
// Latency: o_rx_valid (or o_rx_frame_err) is high in the cycle that follows
// rising edge number 4 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT. Edges are counted
// from the first rising edge that samples the line low. The figure breaks down as:
//   - 2 synchronizer cycles,
//   - 1 cycle to detect the edge and enter START,
//   - (CLKS_PER_BIT-1)/2 + 1 cycles to the start-bit check,
//   - 9*CLKS_PER_BIT cycles for the 8 data bits and the stop bit.
// That is 2 sync + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 fixed pipeline cycles.
module rx_controller #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_active,
    output logic       o_rx_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             fall_edge;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             err_q;
    logic             active_q;

    // Synchronize the line and keep the previous synchronized sample for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx_data;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // A level that is already low (break, stuck line) is not an edge.
    assign fall_edge = prev_q & ~sync2_q;

    // Frame state machine with registered outputs; pulses default low every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (fall_edge) begin
                        state_q  <= START;
                        active_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        if (!sync2_q) begin
                            state_q <= DATA;
                        end else begin
                            // Start bit vanished by mid-bit: treat as a glitch.
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= sync2_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q   <= STOP;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        // Leave at mid stop bit so a back-to-back start edge is caught.
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                        if (sync2_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_byte      = byte_q;
    assign o_rx_valid     = valid_q;
    assign o_rx_frame_err = err_q;
    assign o_rx_active    = active_q;

endmodule

// File: tb/tb_rx_controller.sv
// Scoreboard bench for rx_controller.
// It drives two instances, one at 16 clocks per bit and one at 4 clocks per bit.
// Each sent frame pushes its expected event (valid+byte or frame error) and the
// exact cycle at which that event must appear.
// A negedge monitor pops an entry and compares it whenever a pulse shows up.
module tb_rx_controller;

    localparam int CPB0 = 16;
    localparam int CPB1 = 4;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      rx_line;
    logic [1:0][7:0] rx_byte;
    logic [1:0]      rx_valid;
    logic [1:0]      rx_active;
    logic [1:0]      rx_err;

    exp_t   sb0[$];
    exp_t   sb1[$];
    logic [7:0] last_byte [2];
    longint cyc;
    int     checks;
    int     passes;

    rx_controller #(.CLKS_PER_BIT(CPB0)) u_dut16 (
        .clk            (clk),
        .reset          (rst_n),
        .i_rx_data      (rx_line[0]),
        .o_rx_byte      (rx_byte[0]),
        .o_rx_valid     (rx_valid[0]),
        .o_rx_active    (rx_active[0]),
        .o_rx_frame_err (rx_err[0])
    );

    rx_controller #(.CLKS_PER_BIT(CPB1)) u_dut4 (
        .clk            (clk),
        .reset          (rst_n),
        .i_rx_data      (rx_line[1]),
        .o_rx_byte      (rx_byte[1]),
        .o_rx_valid     (rx_valid[1]),
        .o_rx_active    (rx_active[1]),
        .o_rx_frame_err (rx_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpb(input int i);
        return (i == 0) ? CPB0 : CPB1;
    endfunction

    // Pulse appears this many edges after the first edge that sees the line low.
    function automatic longint lat(input int i);
        return longint'(4 + (cpb(i) - 1) / 2 + 9 * cpb(i));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Drive a level, then wait n clocks; always returns 1 time unit after a rising edge.
    task automatic hold(input int i, input logic v, input int n);
        rx_line[i] = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input exp_t e);
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic send_frame(input int i, input logic [7:0] data, input logic stop);
        exp_t e;
        e.is_err = ~stop;
        e.data   = stop ? data : last_byte[i];
        e.cyc    = cyc + lat(i);
        if (stop) last_byte[i] = data;
        push(i, e);
        hold(i, 1'b0, cpb(i));
        for (int b = 0; b < 8; b++) hold(i, data[b], cpb(i));
        hold(i, stop, cpb(i));
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_byte"}, longint'(rx_byte[i]), 0);
            chk({tag, "_valid"}, longint'(rx_valid[i]), 0);
            chk({tag, "_active"}, longint'(rx_active[i]), 0);
            chk({tag, "_err"}, longint'(rx_err[i]), 0);
        end
    endtask

    task automatic random_frames(input int i, input int n);
        logic [7:0] d;
        logic       s;
        int         gap;
        for (int k = 0; k < n; k++) begin
            d   = 8'($urandom_range(0, 255));
            s   = ($urandom_range(0, 4) != 0);
            send_frame(i, d, s);
            gap = int'($urandom_range(0, 3));
            // A low stop bit leaves the line low; a high gap is needed to make a new edge.
            if (!s) gap = gap + cpb(i);
            if (gap > 0) hold(i, 1'b1, gap);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rx_valid[i] || rx_err[i]) begin
                chk($sformatf("pulse_exclusive%0d", i), longint'(rx_valid[i] & rx_err[i]), 0);
                if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                    chk($sformatf("unexpected_pulse%0d", i), 1, 0);
                end else begin
                    e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk($sformatf("pulse_kind%0d", i), longint'(rx_err[i]), longint'(e.is_err));
                    chk($sformatf("rx_byte%0d", i), longint'(rx_byte[i]), longint'(e.data));
                    chk($sformatf("pulse_cycle%0d", i), cyc, e.cyc);
                    $display("inst%0d %s byte=0x%02h at cycle %0d", i,
                             rx_err[i] ? "frame_err" : "valid", rx_byte[i], cyc);
                end
            end
        end
    end

    initial begin
        int cnt;
        checks       = 0;
        passes       = 0;
        last_byte[0] = 8'h00;
        last_byte[1] = 8'h00;
        rx_line      = 2'b11;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(0, 1'b1, 4);

        // Basic frame, then the line idles.
        send_frame(0, 8'hA5, 1'b1);
        hold(0, 1'b1, 2 * CPB0);
        chk("active_after_a5", longint'(rx_active[0]), 0);

        // Short low glitch on an idle line must abort at the start-bit check.
        cnt = 0;
        rx_line[0] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 4) rx_line[0] = 1'b1;
            @(posedge clk);
            #1;
            if (rx_active[0]) cnt++;
        end
        chk_range("glitch_active_cycles", cnt, 1, 10);

        // Bad stop bit, then the line stays low: no new frame may start.
        send_frame(0, 8'h3C, 1'b0);
        cnt = 0;
        for (int c = 0; c < 3 * CPB0; c++) begin
            @(posedge clk);
            #1;
            if (rx_active[0]) cnt++;
        end
        chk("stuck_low_no_start", cnt, 0);
        hold(0, 1'b1, CPB0);
        send_frame(0, 8'h5A, 1'b1);

        // Back-to-back frames with no idle gap.
        send_frame(0, 8'h00, 1'b1);
        send_frame(0, 8'hFF, 1'b1);
        hold(0, 1'b1, 2 * CPB0);

        // Reset in the middle of data bit 3.
        hold(0, 1'b0, CPB0);
        hold(0, 1'b1, CPB0);
        hold(0, 1'b1, CPB0);
        hold(0, 1'b1, CPB0);
        hold(0, 1'b0, CPB0 / 2);
        chk("active_mid_frame", longint'(rx_active[0]), 1);
        rst_n = 1'b0;
        last_byte[0] = 8'h00;
        last_byte[1] = 8'h00;
        #1 chk_reset_outputs("midrst");
        hold(0, 1'b1, 3);
        rst_n = 1'b1;
        hold(0, 1'b1, 3);
        send_frame(0, 8'h81, 1'b1);
        hold(0, 1'b1, 3);
        random_frames(0, 16);

        // Minimum ratio instance.
        hold(1, 1'b1, 4);
        send_frame(1, 8'h55, 1'b1);
        send_frame(1, 8'hAA, 1'b1);
        hold(1, 1'b1, 3);
        random_frames(1, 24);
        hold(0, 1'b1, 1);
        hold(1, 1'b1, 1);

        // Let outstanding pulses drain, bounded.
        for (int c = 0; c < 2000 && (sb0.size() + sb1.size()) != 0; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        chk("final_byte0", longint'(rx_byte[0]), longint'(last_byte[0]));
        chk("final_byte1", longint'(rx_byte[1]), longint'(last_byte[1]));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
